dotp_shacc: RTL
===============

Name: dotp_shacc

Overview:
- Bit-serial shift-accumulator directly downstream of the dotp adder tree.
- Consumes one signed partial dot product per cycle, one per (weight-bit, data-bit) plane, processed MSB-first.
- Combines the planes by shift-and-add into one full-precision signed result and presents it on a valid/ready output.
- Result register is separate from the accumulator, so accumulation of the next vector overlaps with output back-pressure.

Parameters:
- IW, 8, width of the signed dotp input (a+2 for n=64).
- AW, 32, accumulator and output width; AW > IW.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IW  signed partial sum from dotp.S.
- in_first  in  1  first beat of a vector; clears the accumulator before adding.
- in_shift  in  1  shift the accumulator left by 1 before adding (new bit plane).
- in_neg  in  1  subtract instead of add (sign-bit plane of signed operands).
- in_last  in  1  last beat; result moves to the output register.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  AW  signed result.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: synchronous on rst=1.
  - acc=0, out_data=0, out_valid=0, err=0, state=IDLE.
  - rst overrides every other input in the same cycle.
  - rst mid-vector discards the partial sum and any pending result.
- Handshake:
  - in_ready = !(out_valid && !out_ready); combinational, with no dependence on in_valid.
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Arithmetic on an accepted beat:
  - base = in_first ? 0 : (in_shift ? acc<<1 : acc).
  - x = sign-extend(in_data) to AW.
  - acc_next = base + (in_neg ? -x : x).
  - in_first overrides in_shift.
  - Two's-complement wrap at AW bits; bits shifted out are lost.
- States:
  - IDLE: no open vector.
    - An accepted beat with in_first=1 goes to ACC, or stays in IDLE if in_last=1.
    - An accepted beat with in_first=0 is treated as in_first=1 and sets err.
  - ACC: vector open.
    - A beat with in_first=1 restarts the accumulation from 0, sets err, and stays in ACC.
    - A beat with in_last=1 returns to IDLE.
- Result path:
  - On an accepted in_last beat, out_data <= acc_next and out_valid <= 1 in the next cycle.
  - Latency: 1 cycle from the accepted last beat to out_valid.
  - A single beat with in_first=in_last=1 yields out_data = ±x.
  - out_data holds stable while out_valid && !out_ready.
  - out_valid clears after consumption unless a new last beat is accepted in the same cycle. That case is allowed, since in_ready=1 when out_ready=1; out_valid then stays 1 and out_data takes the new value.
- in_valid=0 cycles: acc and state hold, and gaps are allowed mid-vector.
- err: sticky until rst.

Optional Feature:
- Macro: DOTP_SHACC_SAT_EN.
- Defined:
  - The shift and the add both saturate to the AW-bit signed range: max 2^(AW-1)-1, min -2^(AW-1).
  - Shift overflow is detected when acc[AW-1] != acc[AW-2].
  - A saturated vector sets the extra output port sat (1 bit) to 1 alongside its result, with the same qualification as out_data.
  - Once saturated, the accumulator stays clamped until the next in_first.
- Undefined: plain wrap behaviour, and the sat port is absent.

Test Plan:
- Single beat in_first=in_last=1, in_data=-5 (IW=8), out_ready=1 -> out_valid the next cycle, out_data=-5, err=0.
- 2x2-bit unsigned example over 4 beats:
  - Beats: data 3 (first), 1 (shift), 2 (shift), 1 (shift, last).
  - Result: ((3*2+1)*2+2)*2+1 = 33.
  - Repeat with in_neg=1 on the first beat -> -3*8+1*4+2*2+1 = -15.
- Back-pressure: result pending with out_ready=0 for 5 cycles -> in_ready=0 and out_data stable. Raise out_ready -> consumed; the next vector is accepted in the same cycle.
- Back-to-back: last beat accepted in the same cycle the previous result is consumed -> out_valid stays 1, out_data updates, and no result is lost.
- Protocol errors:
  - A beat without in_first in IDLE -> err=1, and the accumulation starts from that beat.
  - rst mid-vector -> out_valid=0, acc=0, err=0.
- AW=16 with acc=0x7FF0 and in_shift=1:
  - Without the macro -> wraps to 0xFFE0 + x.
  - With DOTP_SHACC_SAT_EN -> 0x7FFF and sat=1.

Source files
------------

// File: rtl/dotp_shacc_if.sv
// Stream bundle between the dotp adder tree, the shift-accumulator and its result consumer.
// The sat flag exists only when DOTP_SHACC_SAT_EN is defined.
interface dotp_shacc_if #(
  parameter int IW = 8,
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_first;
  logic          in_shift;
  logic          in_neg;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          err;
`ifdef DOTP_SHACC_SAT_EN
  logic          sat;

  modport master (
    output in_valid, in_data, in_first, in_shift, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_data, err, sat
  );

  modport slave (
    input  in_valid, in_data, in_first, in_shift, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_data, err, sat
  );
`else
  modport master (
    output in_valid, in_data, in_first, in_shift, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, in_first, in_shift, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_data, err
  );
`endif
endinterface

// File: rtl/dotp_shacc.sv
// MSB-first bit-plane shift-accumulator behind the dotp adder tree, with a decoupled result register.
// Define DOTP_SHACC_SAT_EN for saturating shift/add and the sat result flag; default build wraps.
module dotp_shacc #(
  parameter int IW = 8,
  parameter int AW = 32
) (
  input logic         clk,
  input logic         rst,
  dotp_shacc_if.slave bus
);
  typedef enum logic {IDLE, ACC} state_t;

  state_t state;
  state_t state_next;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] x;
  logic signed [AW-1:0] addend;
  logic [AW-1:0]        out_data_q;
  logic                 out_valid_q;
  logic                 err_q;
  logic                 proto_err;
  logic                 in_ready;
  logic                 beat;
  logic                 consume;
  logic                 start;

  assign in_ready = !(out_valid_q && !bus.out_ready);
  assign beat     = bus.in_valid && in_ready;
  assign consume  = out_valid_q && bus.out_ready;
  // A beat in IDLE always opens a fresh vector, even if in_first was missing.
  assign start    = bus.in_first || (state == IDLE);
  assign x        = {{(AW-IW){bus.in_data[IW-1]}}, bus.in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    proto_err  = 1'b0;
    if (beat) begin
      case (state)
        IDLE:    proto_err = !bus.in_first;
        ACC:     proto_err = bus.in_first;
        default: proto_err = 1'b0;
      endcase
      state_next = bus.in_last ? IDLE : ACC;
    end
  end

`ifdef DOTP_SHACC_SAT_EN
  localparam logic signed [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW-1:0] sum;
  logic                 sat_acc;
  logic                 sat_beat;
  logic                 sat_q;

  // Once clamped, the accumulator is frozen until the next vector starts.
  always_comb begin
    base     = '0;
    if (!start) begin
      base = bus.in_shift ? (acc <<< 1) : acc;
    end
    addend   = bus.in_neg ? -x : x;
    sum      = base + addend;
    acc_next = sum;
    sat_beat = 1'b0;
    if (!start && sat_acc) begin
      acc_next = acc;
      sat_beat = 1'b1;
    end else if (!start && bus.in_shift && (acc[AW-1] != acc[AW-2])) begin
      acc_next = acc[AW-1] ? SMIN : SMAX;
      sat_beat = 1'b1;
    end else if ((base[AW-1] == addend[AW-1]) && (sum[AW-1] != base[AW-1])) begin
      acc_next = base[AW-1] ? SMIN : SMAX;
      sat_beat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_acc <= 1'b0;
      sat_q   <= 1'b0;
    end else if (beat) begin
      sat_acc <= sat_beat;
      if (bus.in_last) begin
        sat_q <= sat_beat;
      end
    end
  end

  assign bus.sat = sat_q;
`else
  always_comb begin
    base = '0;
    if (!start) begin
      base = bus.in_shift ? (acc <<< 1) : acc;
    end
    addend   = bus.in_neg ? -x : x;
    acc_next = base + addend;
  end
`endif

  // A last beat may land in the same cycle the previous result drains, keeping out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (beat) begin
        acc <= acc_next;
      end
      if (beat && bus.in_last) begin
        out_data_q  <= acc_next;
        out_valid_q <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
      if (proto_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
endmodule
